// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: buffers 32-bit fetch words and
// hands decode one 16-bit SuperH instruction per handshake, big-endian half first.
module instr_queue #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [REG_WIDTH-1:0]       in_pc,
  input  logic [31:0]                in_word,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [15:0]                out_instr,
  output logic [REG_WIDTH-1:0]       out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]          word_q  [DEPTH];
  logic [REG_WIDTH-3:0] pcw_q   [DEPTH];
  logic                 start_q [DEPTH];

  logic [PtrW-1:0] wp_q, wp_d;
  logic [PtrW-1:0] rp_q, rp_d;
  logic [CntW-1:0] count_q, count_d;
  logic            lo_sel_q, lo_sel_d;

  logic push;
  logic pop;
  logic retire;
  logic sel;

  // Only bit 1 of the PC selects a half; bit 0 carries no information.
  logic unused_pc0;
  assign unused_pc0 = in_pc[0];

  assign in_ready  = (count_q < CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign sel       = start_q[rp_q] | lo_sel_q;
  assign out_instr = sel ? word_q[rp_q][15:0] : word_q[rp_q][31:16];
  assign out_pc    = {pcw_q[rp_q], sel, 1'b0};

  assign push   = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready & ~flush;
  assign retire = pop & sel;

  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    count_d  = count_q;
    lo_sel_d = lo_sel_q;
    if (flush) begin
      wp_d     = '0;
      rp_d     = '0;
      count_d  = '0;
      lo_sel_d = 1'b0;
    end else begin
      if (push) begin
        wp_d = wp_q + PtrW'(1);
      end
      if (pop) begin
        if (sel) begin
          rp_d     = rp_q + PtrW'(1);
          lo_sel_d = 1'b0;
        end else begin
          lo_sel_d = 1'b1;
        end
      end
      unique case ({push, retire})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      lo_sel_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      lo_sel_q <= lo_sel_d;
    end
  end

  // Storage is deliberately left unreset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      word_q[wp_q]  <= in_word;
      pcw_q[wp_q]   <= in_pc[REG_WIDTH-1:2];
      start_q[wp_q] <= in_pc[1];
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: stimulus queues hand-computed instructions,
// a negedge monitor pops and compares them on every decode handshake.
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_word;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [2:0]  count;

  typedef struct packed {
    logic [15:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  instr_queue #(
    .REG_WIDTH(32),
    .DEPTH    (4)
  ) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_word  (in_word),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc   (out_pc),
    .out_ready(out_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  // Monitor: a handshake will occur at the next rising edge.
  always @(negedge clk) begin
    if (n_reset && out_valid && out_ready && !flush) begin
      exp_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got instr=%h pc=%h, required no output",
                 out_instr, out_pc);
      end else begin
        e = exp_q.pop_front();
        if (out_instr !== e.instr || out_pc !== e.pc) begin
          fails++;
          $display("FAIL out_data: got instr=%h pc=%h, required instr=%h pc=%h",
                   out_instr, out_pc, e.instr, e.pc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [15:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic push_word(input logic [31:0] pc, input logic [31:0] word);
    in_valid = 1'b1;
    in_pc    = pc;
    in_word  = word;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    n_reset   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_word   = '0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_count",     {29'd0, count},     32'd0);
    tick();
    tick();
    n_reset = 1'b1;
    tick();

    // Aligned word: two halves, upper first; no same-cycle bypass.
    out_ready = 1'b1;
    expect_out(16'hA1B2, 32'h100);
    expect_out(16'hC3D4, 32'h102);
    in_valid = 1'b1;
    in_pc    = 32'h100;
    in_word  = 32'hA1B2C3D4;
    #1;
    check("no_bypass", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    check("aligned_count1", {29'd0, count}, 32'd1);
    tick();
    tick();
    check("aligned_count0", {29'd0, count},     32'd0);
    check("aligned_empty",  {31'd0, out_valid}, 32'd0);

    // Odd start: only the lower half is issued.
    expect_out(16'h2222, 32'h206);
    push_word(32'h206, 32'h11112222);
    check("odd_count1", {29'd0, count}, 32'd1);
    tick();
    check("odd_count0", {29'd0, count}, 32'd0);

    // Fill to capacity (pointers start at 2, so they wrap), then drain.
    out_ready = 1'b0;
    expect_out(16'h3001, 32'h300);
    expect_out(16'h3002, 32'h302);
    expect_out(16'h3003, 32'h304);
    expect_out(16'h3004, 32'h306);
    expect_out(16'h3005, 32'h308);
    expect_out(16'h3006, 32'h30A);
    expect_out(16'h3007, 32'h30C);
    expect_out(16'h3008, 32'h30E);
    push_word(32'h300, 32'h30013002);
    push_word(32'h304, 32'h30033004);
    push_word(32'h308, 32'h30053006);
    push_word(32'h30C, 32'h30073008);
    check("full_count",    {29'd0, count},    32'd4);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    push_word(32'h310, 32'hDEADBEEF);
    check("full_no_write", {29'd0, count}, 32'd4);
    out_ready = 1'b1;
    tick();
    check("full_half_count", {29'd0, count},    32'd4);
    check("full_half_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("retire_count", {29'd0, count},    32'd3);
    check("retire_ready", {31'd0, in_ready}, 32'd1);
    repeat (6) tick();
    check("full_drained", {29'd0, count}, 32'd0);

    // Flush with 3 words queued and the head's upper half consumed.
    out_ready = 1'b0;
    expect_out(16'h5001, 32'h500);
    push_word(32'h500, 32'h50015002);
    push_word(32'h504, 32'h50035004);
    push_word(32'h508, 32'h50055006);
    out_ready = 1'b1;
    tick();
    exp_q.delete();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'h600;
    in_word  = 32'h66666666;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_count", {29'd0, count},     32'd0);
      check("flush_valid", {31'd0, out_valid}, 32'd0);
    end
    flush = 1'b0;
    expect_out(16'hAAAA, 32'h400);
    expect_out(16'h5555, 32'h402);
    push_word(32'h400, 32'hAAAA5555);
    check("post_flush_count", {29'd0, count}, 32'd1);
    tick();
    tick();
    check("post_flush_drain", {29'd0, count}, 32'd0);

    // Push and retire on the same edge keep count steady.
    out_ready = 1'b0;
    expect_out(16'h7001, 32'h700);
    expect_out(16'h7002, 32'h702);
    expect_out(16'h7003, 32'h704);
    expect_out(16'h7004, 32'h706);
    expect_out(16'h7005, 32'h708);
    expect_out(16'h7006, 32'h70A);
    push_word(32'h700, 32'h70017002);
    push_word(32'h704, 32'h70037004);
    out_ready = 1'b1;
    tick();
    push_word(32'h708, 32'h70057006);
    check("push_retire_count", {29'd0, count}, 32'd2);
    check("push_retire_pc",    out_pc,         32'h704);
    repeat (4) tick();
    check("push_retire_drain", {29'd0, count}, 32'd0);

    // Reset mid-stream with three words held.
    out_ready = 1'b0;
    push_word(32'h800, 32'h80018002);
    push_word(32'h804, 32'h80038004);
    push_word(32'h808, 32'h80058006);
    check("pre_reset_count", {29'd0, count}, 32'd3);
    n_reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready},  32'd1);
    check("mid_rst_count", {29'd0, count},     32'd0);
    tick();
    n_reset = 1'b1;
    tick();
    out_ready = 1'b1;
    expect_out(16'h9999, 32'h900);
    expect_out(16'h8888, 32'h902);
    push_word(32'h900, 32'h99998888);
    tick();
    tick();
    check("post_rst_drain", {29'd0, count}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
